// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter family (up counter and down counter).
//   DEFAULT_WIDTH : count width shared with the 4-bit up counter
//   state_t       : down-counter control state encoding
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : counter_pkg

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
// Loadable WIDTH-bit down counter used as a period / timeout generator.
// Counts from a loaded value toward zero, pulses tc for one cycle when the
// count reaches zero, then either stops (one-shot) or reloads (periodic).
//
// Ports
//   clk          : single clock, all state changes on the rising edge
//   reset        : synchronous, active-low reset
//   load         : load din into the count and the reload register
//   din          : load value
//   en           : count enable, one decrement per enabled cycle
//   auto_reload  : 1 = periodic, 0 = one-shot (sampled every cycle)
//   Q            : current count (registered)
//   tc           : terminal-count pulse, one cycle (registered)
//   busy         : high while counting (RUN)
//   done         : high once a one-shot expired or zero was loaded (DONE)
// -----------------------------------------------------------------------------
module down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] reload_nxt_s;
    logic             tc_r;
    logic             tc_nxt_s;
    logic             busy_r;
    logic             done_r;

    // Next-state / next-count logic: load beats counting, tc defaults low.
    always_comb begin
        state_nxt_s  = state_r;
        q_nxt_s      = q_r;
        reload_nxt_s = reload_r;
        tc_nxt_s     = 1'b0;

        if (load) begin
            // A load in the cycle the count would hit zero swallows that tc,
            // because tc_nxt_s is never raised on this branch.
            reload_nxt_s = din;
            q_nxt_s      = din;
            if (din != ZERO) begin
                state_nxt_s = RUN;
            end else begin
                state_nxt_s = DONE;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                RUN: begin
                    if (en) begin
                        if (q_r > ONE) begin
                            q_nxt_s = q_r - ONE;
                        end else if (q_r == ONE) begin
                            q_nxt_s  = ZERO;
                            tc_nxt_s = 1'b1;
                            if (auto_reload) begin
                                state_nxt_s = RUN;
                            end else begin
                                state_nxt_s = DONE;
                            end
                        end else begin
                            // Count sits at zero after a periodic tc: reload,
                            // or stop quietly if periodic mode was dropped.
                            if (auto_reload) begin
                                q_nxt_s = reload_r;
                            end else begin
                                state_nxt_s = DONE;
                            end
                        end
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                DONE: begin
                    q_nxt_s = ZERO;
                end
                default: begin
                    // Unreachable encoding: park safely with a cleared count.
                    state_nxt_s = IDLE;
                    q_nxt_s     = ZERO;
                end
            endcase
        end
    end

    // State, count, reload value and status flags, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            q_r      <= ZERO;
            reload_r <= ZERO;
            tc_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            q_r      <= q_nxt_s;
            reload_r <= reload_nxt_s;
            tc_r     <= tc_nxt_s;
            busy_r   <= (state_nxt_s == RUN);
            done_r   <= (state_nxt_s == DONE);
        end
    end

    assign Q    = q_r;
    assign tc   = tc_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule : down_counter

// File: doc/down_counter.md
# down_counter

Loadable WIDTH-bit down counter: counts from a loaded value toward zero and flags the terminal count. It runs as a one-shot or with auto-reload. It is the decrementing counterpart to the existing 4-bit up counter and serves as a period/timeout generator beside it on the same clock. Default WIDTH matches the up counter's 4-bit output.

## Interface
- WIDTH, 4, counter and load-value width.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low; sampled only on rising clk edge.
- load  in  1  load din into counter and reload register; highest priority after reset.
- din  in  WIDTH  load value.
- en  in  1  count enable; one decrement per enabled cycle.
- auto_reload  in  1  1 = periodic mode, 0 = one-shot; sampled every cycle, not latched.
- Q  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse, one cycle, registered.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (one-shot expired or zero loaded).

## Operation
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE); both registered via state.
- Reset (reset==0 at edge): Q=0, reload_reg=0, tc=0, state=IDLE; busy=0, done=0. Overrides load/en.
- Priority per edge: reset > load > en. tc defaults to 0 every cycle unless set below.
- load=1, any state: reload_reg<=din, Q<=din.
  - din!=0 -> RUN.
  - din==0 -> DONE, with tc=0.
  - A load in the cycle Q would reach 0 suppresses that tc.
- IDLE: Q holds; en ignored.
- RUN, en=0: Q, state hold.
- RUN, en=1:
  - Q>1: Q<=Q-1.
  - Q==1: Q<=0, tc<=1; next state RUN if auto_reload else DONE.
  - Q==0 (only reachable in periodic mode): if auto_reload, Q<=reload_reg and stay RUN; else -> DONE, Q holds 0, no tc.
- DONE: Q holds 0; en and auto_reload ignored; exit only via load or reset.
- No wrap below zero in any state. Q never transitions 0 -> all-ones.
- Arithmetic: plain WIDTH-bit decrement; reload_reg is WIDTH bits; no carries exported.

## Timing
- Load latency: Q==din on the edge after load is sampled. busy/done update on the same edge.
- One-shot, load N (N>=1), en held high: Q = N, N-1, …, 1, 0 on successive edges.
  - tc high for exactly the one cycle in which Q first shows 0.
  - done rises on that same edge.
- Periodic, load N, en held high: sequence N…1,0,N…1,0; period N+1 cycles; tc once per period, aligned with Q==0.
- en gaps stretch the sequence; tc stays one cycle wide; Q holds during gaps.
- Reset mid-count: outputs at reset values on the next edge; no tc emitted.
- Simultaneous load and en: load wins; no decrement that cycle.

## Structure
- Shared package (counter_pkg): state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10; default width constant 4 shared with the up counter.
- Single module; no sub-module. Next-state/next-Q combinational block plus one registered block.
- Bench clocking: 100 ns period, timescale 1ns/100ps; VCD dump enabled.

## Test plan
- Reset: drive reset=0 for 2 cycles with load=1, din=4'h9 -> Q=0, tc=0, busy=0, done=0 throughout.
- One-shot: load 4'h3, auto_reload=0, en=1 ->
  - Q = 3,2,1,0 on successive edges.
  - tc high only with Q=0; done=1 and busy=0 from then on.
  - Q stays 0 for 5 further cycles.
- Periodic: load 4'h2, auto_reload=1, en=1 -> Q = 2,1,0,2,1,0,2; tc pulses at cycles 3 and 6 after load; busy stays 1.
- Enable gaps: load 4'h4, en toggled 1,0,0,1,1,1 -> Q = 4,3,3,3,2,1,0; tc one cycle wide.
- Boundaries:
  - load 4'h0 -> done=1 next edge, tc never asserted.
  - load 4'hF in periodic mode -> 16-cycle period, no wrap to 4'hF other than by reload.
- Conflicts:
  - load 4'h7 asserted on the cycle Q==1 -> next Q=7, no tc.
  - reset asserted mid-count at Q=5 -> Q=0, state IDLE, en then ignored.
